// File: rtl/shift_seq_ctrl_if.sv
// shift_seq_ctrl_if: command, shifter-control and result bundle for the shift sequencer
//   slave  : controller view (cmd_* in / cmd_ready out, sh_* out / sh_d_out in, res_* out / res_ready in)
//   master : environment view, directions mirrored
interface shift_seq_ctrl_if #(parameter int AMT_W = 3);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [AMT_W-1:0] cmd_amt;
  logic [7:0]       cmd_data;
  logic [2:0]       sh_op;
  logic [1:0]       sh_shamt;
  logic [7:0]       sh_d_in;
  logic [7:0]       sh_d_out;
  logic             res_valid;
  logic             res_ready;
  logic [7:0]       res_data;
  logic             res_err;
  modport slave (
    input  cmd_valid, cmd_op, cmd_amt, cmd_data, sh_d_out, res_ready,
    output cmd_ready, sh_op, sh_shamt, sh_d_in, res_valid, res_data, res_err
  );
  modport master (
    output cmd_valid, cmd_op, cmd_amt, cmd_data, sh_d_out, res_ready,
    input  cmd_ready, sh_op, sh_shamt, sh_d_in, res_valid, res_data, res_err
  );
endinterface

// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: sequences LOAD and bounded-shamt shift opcodes to an 8-bit shifter for arbitrary shift amounts
//   clk, reset : clock, synchronous active-high reset
//   bus.cmd_*  : command handshake (op, amount, data)
//   bus.sh_*   : shifter control (op, shamt, load data) and shifter register readback
//   bus.res_*  : result handshake (data, illegal-op flag)
//   Macro SHIFT_ZERO_SKIP_EN: stop shifting early once the shifter register reads zero
module shift_seq_ctrl #(
  parameter int MAX_STEP = 3,
  parameter int AMT_W    = 3
) (
  input logic             clk,
  input logic             reset,
  shift_seq_ctrl_if.slave bus
);
  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [AMT_W-1:0] MAX = AMT_W'(MAX_STEP);
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
  state_t state_q, state_d;
  logic [2:0] op_q, op_d;
  logic [AMT_W-1:0] rem_q, rem_d, step;
  logic [7:0] data_q, data_d;
  logic err_q, err_d, res_valid_q, res_valid_d, skip, take;
`ifdef SHIFT_ZERO_SKIP_EN
  assign skip = bus.sh_d_out == 8'h00;
`else
  assign skip = 1'b0;
`endif
  assign step = rem_q < MAX ? rem_q : MAX;
  assign take = res_valid_q && bus.res_ready;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      op_q        <= OP_NOP;
      rem_q       <= '0;
      data_q      <= 8'h00;
      err_q       <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      rem_q       <= rem_d;
      data_q      <= data_d;
      err_q       <= err_d;
      res_valid_q <= res_valid_d;
    end
  end
  // res_valid rises one cycle after entering DONE so sh_d_out has settled under NOP
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    rem_d         = rem_q;
    data_d        = data_q;
    err_d         = err_q;
    res_valid_d   = res_valid_q;
    bus.cmd_ready = 1'b0;
    bus.sh_op     = OP_NOP;
    bus.sh_shamt  = 2'd0;
    bus.sh_d_in   = 8'h00;
    case (state_q)
      IDLE: begin
        bus.cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          op_d    = bus.cmd_op;
          rem_d   = bus.cmd_amt;
          data_d  = bus.cmd_data;
          err_d   = !(bus.cmd_op inside {3'b010, 3'b011, 3'b100});
          state_d = LOAD;
        end
      end
      LOAD: begin
        bus.sh_op   = OP_LOAD;
        bus.sh_d_in = data_q;
        state_d     = (!err_q && rem_q != '0) ? SHIFT : DONE;
      end
      SHIFT: begin
        if (skip) state_d = DONE;
        else begin
          bus.sh_op    = op_q;
          bus.sh_shamt = step[1:0];
          rem_d        = rem_q - step;
          state_d      = rem_q <= MAX ? DONE : SHIFT;
        end
      end
      DONE: begin
        res_valid_d = !take;
        if (take) begin
          state_d = IDLE;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  assign bus.res_valid = res_valid_q;
  assign bus.res_err   = err_q;
  assign bus.res_data  = res_valid_q ? bus.sh_d_out : 8'h00;
endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb_shift_seq_ctrl: scoreboard bench for shift_seq_ctrl with an attached shifter model
module tb_shift_seq_ctrl;
  localparam int AMT_W = 3;
  localparam int MAX_STEP = 3;
`ifdef SHIFT_ZERO_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif
  typedef struct {
    logic [7:0] data;
    logic       err;
    int         lat;
    int         acc;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [7:0] sh_reg;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  bit force_bp = 1'b0;
  bit mon_seen = 1'b0;
  bit idle_chk = 1'b0;
  int hc = 0;
  exp_t mon_e;
  exp_t exp_q[$];

  shift_seq_ctrl_if #(.AMT_W(AMT_W)) bus();
  shift_seq_ctrl #(.MAX_STEP(MAX_STEP), .AMT_W(AMT_W)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] shf(input logic [2:0] op, input logic [7:0] v, input int n);
    logic signed [7:0] s;
    s = v;
    s = s >>> n;
    return op == 3'b010 ? v << n : op == 3'b011 ? v >> n : s;
  endfunction

  always @(posedge clk)
    if (reset) sh_reg <= 8'h00;
    else if (bus.sh_op == 3'b001) sh_reg <= bus.sh_d_in;
    else if (bus.sh_op inside {3'b010, 3'b011, 3'b100}) sh_reg <= shf(bus.sh_op, sh_reg, int'(bus.sh_shamt));
  assign bus.sh_d_out = sh_reg;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic noise();
    bus.cmd_valid = !bus.cmd_ready && ($urandom_range(0, 1) == 1);
    bus.cmd_op    = 3'($urandom);
    bus.cmd_amt   = AMT_W'($urandom);
    bus.cmd_data  = 8'($urandom);
  endtask

  task automatic send(input logic [2:0] op, input logic [AMT_W-1:0] amt, input logic [7:0] data);
    logic [2:0] t_op[$];
    logic [1:0] t_sh[$];
    logic [7:0] v;
    int r, s;
    bit legal;
    exp_t e;
    legal = op inside {3'b010, 3'b011, 3'b100};
    t_op.push_back(3'b001);
    t_sh.push_back(2'd0);
    v = data;
    r = legal ? int'(amt) : 0;
    while (r > 0) begin
      if (SKIP && v == 8'h00) begin
        t_op.push_back(3'b000);
        t_sh.push_back(2'd0);
        break;
      end
      s = r < MAX_STEP ? r : MAX_STEP;
      t_op.push_back(op);
      t_sh.push_back(2'(s));
      v = shf(op, v, s);
      r -= s;
    end
    t_op.push_back(3'b000);
    t_sh.push_back(2'd0);
    e.data = legal ? shf(op, data, int'(amt)) : data;
    e.err  = !legal;
    e.lat  = t_op.size();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.cmd_ready) break;
      noise();
    end
    if (!bus.cmd_ready) begin
      chk("cmd_ready_timeout", 32'(bus.cmd_ready), 1);
      return;
    end
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_amt   = amt;
    bus.cmd_data  = data;
    e.acc = cyc + 1;
    exp_q.push_back(e);
    for (int i = 0; i < t_op.size(); i++) begin
      @(negedge clk);
      noise();
      chk("sh_op", 32'(bus.sh_op), 32'(t_op[i]));
      chk("sh_shamt", 32'(bus.sh_shamt), 32'(t_sh[i]));
      chk("sh_d_in", 32'(bus.sh_d_in), i == 0 ? 32'(data) : 32'd0);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 500 && exp_q.size() > 0; i++) begin
      @(negedge clk);
      noise();
    end
    chk("drain_timeout", 32'(exp_q.size()), 0);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  initial begin
    bus.res_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (idle_chk) begin
        chk("idle_after_accept_ready", 32'(bus.cmd_ready), 1);
        chk("idle_after_accept_valid", 32'(bus.res_valid), 0);
        chk("idle_after_accept_err", 32'(bus.res_err), 0);
        idle_chk = 1'b0;
      end
      if (reset || !bus.res_valid) begin
        bus.res_ready = 1'b0;
        continue;
      end
      if (!mon_seen) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 32'(bus.res_valid), 0);
          bus.res_ready = 1'b1;
          continue;
        end
        mon_e = exp_q[0];
        mon_seen = 1'b1;
        hc = 0;
        chk("latency", 32'(cyc - mon_e.acc), 32'(mon_e.lat));
      end
      chk("res_data", 32'(bus.res_data), 32'(mon_e.data));
      chk("res_err", 32'(bus.res_err), 32'(mon_e.err));
      chk("cmd_ready_in_done", 32'(bus.cmd_ready), 0);
      chk("sh_op_in_done", 32'(bus.sh_op), 0);
      bus.res_ready = (force_bp && hc < 3) ? 1'b0 : ($urandom_range(0, 2) != 0);
      hc++;
      if (bus.res_ready) begin
        void'(exp_q.pop_front());
        mon_seen = 1'b0;
        idle_chk = 1'b1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0] op;
    logic [7:0] d;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'b000;
    bus.cmd_amt   = '0;
    bus.cmd_data  = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_cmd_ready", 32'(bus.cmd_ready), 1);
    chk("reset_res_valid", 32'(bus.res_valid), 0);
    chk("reset_sh_op", 32'(bus.sh_op), 0);
    chk("reset_sh_shamt", 32'(bus.sh_shamt), 0);
    chk("reset_sh_d_in", 32'(bus.sh_d_in), 0);
    chk("reset_res_err", 32'(bus.res_err), 0);
    reset = 1'b0;
    force_bp = 1'b1;
    send(3'b010, 3'd5, 8'h01);
    drain();
    force_bp = 1'b0;
    send(3'b100, 3'd7, 8'h80);
    send(3'b011, 3'd0, 8'hA5);
    send(3'b000, 3'd4, 8'h3C);
    send(3'b010, 3'd7, 8'h80);
    send(3'b100, 3'd3, 8'h00);
    drain();
    for (int i = 0; i < 50 && !bus.cmd_ready; i++) @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 3'b010;
    bus.cmd_amt   = 3'd6;
    bus.cmd_data  = 8'h11;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    chk("rst_test_load", 32'(bus.sh_op), 1);
    @(negedge clk);
    chk("rst_test_shift_op", 32'(bus.sh_op), 2);
    chk("rst_test_shift_shamt", 32'(bus.sh_shamt), 3);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_cmd_ready", 32'(bus.cmd_ready), 1);
    chk("rst_mid_res_valid", 32'(bus.res_valid), 0);
    chk("rst_mid_sh_op", 32'(bus.sh_op), 0);
    chk("rst_mid_res_err", 32'(bus.res_err), 0);
    reset = 1'b0;
    for (int n = 0; n < 60; n++) begin
      op = $urandom_range(0, 4) == 0 ? 3'($urandom) : 3'($urandom_range(2, 4));
      d = $urandom_range(0, 3) == 0 ? ($urandom_range(0, 1) == 1 ? 8'h80 : 8'h00) : 8'($urandom);
      send(op, AMT_W'($urandom), d);
    end
    drain();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
